iob_ptfloat_unpack: RTL and testbench



---
 rtl/iob_ptfloat_unpack.sv | 157 +++++++++++++++
 tb/tb_iob_ptfloat_unpack.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ptfloat_unpack.sv
// Iterative pt-float unpacker: packed word -> sign-extended exponent + left-aligned mantissa.
// Optional normalisation stage enabled by defining IOB_PTFLOAT_UNPACK_NORM_EN.
module iob_ptfloat_unpack #(
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned EW_W      = 4,
  localparam int unsigned MAN_MAX_W = DATA_W - EW_W,
  localparam int unsigned EXP_MAX_W = (2 ** EW_W) - 1
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 cke_i,
  input  logic                 start_i,
  input  logic [DATA_W-1:0]    data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [EXP_MAX_W-1:0] exp_o,
  output logic [MAN_MAX_W-1:0] man_o
);

  localparam logic [EXP_MAX_W-1:0] EXP_MIN = {1'b1, {(EXP_MAX_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXTRACT,
    S_ALIGN,
    S_NORM,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [EW_W-1:0]        r_ew;
  logic [EW_W-1:0]        r_cnt;
  logic [MAN_MAX_W-1:0]   r_work;
  logic [EXP_MAX_W-1:0]   r_exp;
  logic [EXP_MAX_W-1:0]   r_mask;
  logic                   r_busy;
  logic                   r_done;
  logic [EXP_MAX_W-1:0]   r_exp_o;
  logic [MAN_MAX_W-1:0]   r_man_o;

  logic [EW_W-1:0]        w_ew;
  logic [MAN_MAX_W-1:0]   w_work_shl;
  logic [EXP_MAX_W-1:0]   w_fin_exp;

  assign w_ew       = data_i[EW_W-1:0];
  assign w_work_shl = {r_work[MAN_MAX_W-2:0], 1'b0};
  // After alignment the low ew bits are zero, so an all-zero register means a zero mantissa field
  assign w_fin_exp  = (r_work == '0) ? EXP_MIN : r_exp;

`ifdef IOB_PTFLOAT_UNPACK_NORM_EN
  localparam int unsigned NSTEP_W = $clog2(MAN_MAX_W);

  logic [NSTEP_W-1:0]   r_nsteps;
  logic [EXP_MAX_W-1:0] w_norm_exp;
  logic [NSTEP_W-1:0]   w_norm_steps;

  assign w_norm_exp   = r_exp - EXP_MAX_W'(1);
  assign w_norm_steps = r_nsteps + NSTEP_W'(1);

  // True when one more left shift keeps the value and the step cap is not reached
  function automatic logic norm_ok(input logic [MAN_MAX_W-1:0] man,
                                   input logic [EXP_MAX_W-1:0] exp,
                                   input logic [NSTEP_W-1:0]   steps);
    return (man[MAN_MAX_W-1] == man[MAN_MAX_W-2]) && (exp != EXP_MIN) &&
           (steps < NSTEP_W'(MAN_MAX_W - 2));
  endfunction
`endif

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      r_state  <= S_IDLE;
      r_ew     <= '0;
      r_cnt    <= '0;
      r_work   <= '0;
      r_exp    <= '0;
      r_mask   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_exp_o  <= '0;
      r_man_o  <= '0;
`ifdef IOB_PTFLOAT_UNPACK_NORM_EN
      r_nsteps <= '0;
`endif
    end else if (cke_i) begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_work  <= data_i[DATA_W-1:EW_W];
            r_exp   <= '0;
            r_mask  <= '0;
            r_ew    <= w_ew;
            r_cnt   <= w_ew;
            r_busy  <= 1'b1;
            r_state <= (w_ew == '0) ? S_ALIGN : S_EXTRACT;
          end
        end
        // Pull exponent bits LSB-first, keeping the partial value sign-extended
        S_EXTRACT: begin
          r_exp  <= (r_exp & r_mask) | ({EXP_MAX_W{r_work[0]}} & ~r_mask);
          r_mask <= {r_mask[EXP_MAX_W-2:0], 1'b1};
          r_work <= {1'b0, r_work[MAN_MAX_W-1:1]};
          if (r_cnt == EW_W'(1)) begin
            r_cnt   <= r_ew;
            r_state <= S_ALIGN;
          end else begin
            r_cnt <= r_cnt - EW_W'(1);
          end
        end
        S_ALIGN: begin
          if (r_cnt != '0) begin
            r_work <= w_work_shl;
            r_cnt  <= r_cnt - EW_W'(1);
          end else begin
            r_exp <= w_fin_exp;
`ifdef IOB_PTFLOAT_UNPACK_NORM_EN
            if (norm_ok(r_work, w_fin_exp, '0)) begin
              r_nsteps <= '0;
              r_state  <= S_NORM;
            end else
`endif
            begin
              r_exp_o <= w_fin_exp;
              r_man_o <= r_work;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
`ifdef IOB_PTFLOAT_UNPACK_NORM_EN
        S_NORM: begin
          r_work   <= w_work_shl;
          r_exp    <= w_norm_exp;
          r_nsteps <= w_norm_steps;
          if (!norm_ok(w_work_shl, w_norm_exp, w_norm_steps)) begin
            r_exp_o <= w_norm_exp;
            r_man_o <= w_work_shl;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign exp_o  = r_exp_o;
  assign man_o  = r_man_o;

endmodule

// File: tb/tb_iob_ptfloat_unpack.sv
// Self-checking bench for iob_ptfloat_unpack: directed vector table, hand-written
// handshake/reset sequences and randomized words against an arithmetic reference model.
module tb_iob_ptfloat_unpack;

  localparam int BUDGET = 80;
  localparam int NV     = 7;

  logic        clk_i;
  logic        arst_i;
  logic        cke_i;
  logic        start_i;
  logic [31:0] data_i;
  logic        busy_o;
  logic        done_o;
  logic [14:0] exp_o;
  logic [27:0] man_o;

  int checks   = 0;
  int failures = 0;

  iob_ptfloat_unpack #(.DATA_W(32), .EW_W(4)) dut (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .cke_i   (cke_i),
    .start_i (start_i),
    .data_i  (data_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .exp_o   (exp_o),
    .man_o   (man_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] data;
    logic [14:0] exp;
    logic [27:0] man;
    int          lat;
  } vec_t;

  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: decode fields as integers, scale, then normalise by doubling
  function automatic void model(input logic [31:0] d, output logic [14:0] e,
                                output logic [27:0] m, output int lat);
    int     ew;
    int     mw;
    int     n;
    longint mf;
    longint ef;
    longint ms;
    ew = int'(d[3:0]);
    mw = 28 - ew;
    mf = longint'(d >> (4 + ew));
    if (mf >= (longint'(1) << (mw - 1))) mf = mf - (longint'(1) << mw);
    ef = longint'(d >> 4) & ((longint'(1) << ew) - 1);
    if (ew > 0 && ef >= (longint'(1) << (ew - 1))) ef = ef - (longint'(1) << ew);
    n = 0;
    if (mf == 0) begin
      e = 15'h4000;
      m = '0;
    end else begin
      ms = mf * (longint'(1) << ew);
`ifdef IOB_PTFLOAT_UNPACK_NORM_EN
      while (n < 26 && ms >= -(longint'(1) << 26) && ms < (longint'(1) << 26) && ef > -16384) begin
        ms = ms * 2;
        ef = ef - 1;
        n++;
      end
`endif
      e = 15'(ef);
      m = 28'(ms);
    end
    lat = 2 + 2 * ew + n;
  endfunction

  // Start one conversion; cycle k is the k-th cycle after the start cycle
  task automatic run_op(input logic [31:0] d, input int cke_lo_at, input int cke_lo_len,
                        input int spur_at, input logic [31:0] spur_d,
                        output int lat, output logic [14:0] eo, output logic [27:0] mo,
                        output int bc);
    @(negedge clk_i);
    start_i = 1'b1;
    data_i  = d;
    lat = -1;
    bc  = 0;
    eo  = '0;
    mo  = '0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk_i);
      start_i = (k == spur_at);
      if (k == spur_at) data_i = spur_d;
      cke_i = !(k >= cke_lo_at && k < cke_lo_at + cke_lo_len);
      if (busy_o) bc++;
      if (done_o) begin
        lat = k;
        eo  = exp_o;
        mo  = man_o;
        break;
      end
    end
    cke_i   = 1'b1;
    start_i = 1'b0;
    if (lat < 0) $display("FAIL timeout: no done within %0d cycles for data %0h", BUDGET, d);
    @(negedge clk_i);
    chk("done_one_cycle", 64'(done_o), 64'(0));
    chk("busy_drops", 64'(busy_o), 64'(0));
  endtask

  initial begin
    int          lat;
    int          bc;
    int          dc;
    int          elat;
    logic [14:0] eo;
    logic [27:0] mo;
    logic [14:0] ee;
    logic [27:0] em;
    logic [31:0] d;
    logic [31:0] msk;

    arst_i  = 1'b1;
    cke_i   = 1'b1;
    start_i = 1'b0;
    data_i  = '0;

    vecs[0] = '{32'h4000_0000, 15'h0000, 28'h400_0000, 2};
    vecs[1] = '{32'h4000_0053, 15'h7FFD, 28'h400_0000, 8};
    vecs[2] = '{32'h0000_0055, 15'h4000, 28'h000_0000, 12};
    vecs[6] = '{32'h000C_000F, 15'h4000, 28'h000_8000, 32};
`ifdef IOB_PTFLOAT_UNPACK_NORM_EN
    vecs[3] = '{32'h1000_0000, 15'h7FFE, 28'h400_0000, 4};
    vecs[4] = '{32'hFFFF_FFF1, 15'h7FE5, 28'h800_0000, 30};
    vecs[5] = '{32'h0008_000F, 15'h7FF5, 28'h400_0000, 43};
`else
    vecs[3] = '{32'h1000_0000, 15'h0000, 28'h100_0000, 2};
    vecs[4] = '{32'hFFFF_FFF1, 15'h7FFF, 28'hFFF_FFFE, 4};
    vecs[5] = '{32'h0008_000F, 15'h0000, 28'h000_8000, 32};
`endif

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_exp", 64'(exp_o), 64'(0));
    chk("rst_man", 64'(man_o), 64'(0));
    arst_i = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].data, 0, 0, 0, 32'h0, lat, eo, mo, bc);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_exp", i), 64'(eo), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_man", i), 64'(mo), 64'(vecs[i].man));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].lat));
    end

    // Clock-enable stall mid-extract plus a start pulse that must be ignored
    run_op(32'h4000_0053, 2, 3, 5, 32'h0000_0055, lat, eo, mo, bc);
    chk("stall_lat", 64'(lat), 64'(11));
    chk("stall_exp", 64'(eo), 64'(15'h7FFD));
    chk("stall_man", 64'(mo), 64'(28'h400_0000));
    chk("stall_busy_cycles", 64'(bc), 64'(11));

    // Reset in the middle of a conversion
    @(negedge clk_i);
    start_i = 1'b1;
    data_i  = 32'h0000_0055;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (k == 4) arst_i = 1'b1;
    end
    @(negedge clk_i);
    arst_i = 1'b0;
    chk("abort_busy", 64'(busy_o), 64'(0));
    chk("abort_done", 64'(done_o), 64'(0));
    chk("abort_exp", 64'(exp_o), 64'(0));
    chk("abort_man", 64'(man_o), 64'(0));
    dc = 0;
    repeat (14) begin
      @(negedge clk_i);
      if (done_o || busy_o) dc++;
    end
    chk("abort_no_done", 64'(dc), 64'(0));
    run_op(32'h4000_0000, 0, 0, 0, 32'h0, lat, eo, mo, bc);
    chk("after_abort_lat", 64'(lat), 64'(2));
    chk("after_abort_man", 64'(mo), 64'(28'h400_0000));

    // Start and reset in the same cycle
    @(negedge clk_i);
    arst_i  = 1'b1;
    start_i = 1'b1;
    data_i  = 32'h4000_0000;
    @(negedge clk_i);
    arst_i  = 1'b0;
    start_i = 1'b0;
    chk("rst_wins_busy", 64'(busy_o), 64'(0));
    @(negedge clk_i);
    chk("rst_wins_busy2", 64'(busy_o), 64'(0));
    chk("rst_wins_done", 64'(done_o), 64'(0));

    // done_o held while clock enable is low in the DONE cycle
    @(negedge clk_i);
    start_i = 1'b1;
    data_i  = 32'h4000_0000;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    chk("hold_done_first", 64'(done_o), 64'(1));
    cke_i = 1'b0;
    @(negedge clk_i);
    chk("hold_done_frozen", 64'(done_o), 64'(1));
    chk("hold_busy_frozen", 64'(busy_o), 64'(1));
    cke_i = 1'b1;
    @(negedge clk_i);
    chk("hold_done_release", 64'(done_o), 64'(0));

    // Start during DONE is ignored; start in the following cycle is accepted
    @(negedge clk_i);
    start_i = 1'b1;
    data_i  = 32'h4000_0000;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_first_done", 64'(done_o), 64'(1));
    start_i = 1'b1;
    data_i  = 32'h4000_0053;
    @(negedge clk_i);
    chk("b2b_ignored_busy", 64'(busy_o), 64'(0));
    chk("b2b_ignored_done", 64'(done_o), 64'(0));
    lat = -1;
    for (int k = 4; k <= BUDGET; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (k == 4) chk("b2b_accepted_busy", 64'(busy_o), 64'(1));
      if (done_o) begin
        lat = k;
        eo  = exp_o;
        mo  = man_o;
        break;
      end
    end
    chk("b2b_lat", 64'(lat), 64'(11));
    chk("b2b_exp", 64'(eo), 64'(15'h7FFD));
    chk("b2b_man", 64'(mo), 64'(28'h400_0000));
    @(negedge clk_i);

    // Randomized words against the reference model
    for (int i = 0; i < 40; i++) begin
      d = $urandom();
      if ($urandom_range(0, 4) == 0) begin
        msk = (32'h1 << (4 + int'(d[3:0]))) - 32'h1;
        d   = d & msk;
      end
      dc = int'($urandom_range(0, 1));
      model(d, ee, em, elat);
      run_op(d, 1, dc, 0, 32'h0, lat, eo, mo, bc);
      chk($sformatf("rnd%0d_lat(%0h)", i, d), 64'(lat), 64'(elat + dc));
      chk($sformatf("rnd%0d_exp(%0h)", i, d), 64'(eo), 64'(ee));
      chk($sformatf("rnd%0d_man(%0h)", i, d), 64'(mo), 64'(em));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
